// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one partial product per RUN cycle,
// N RUN cycles per operation, product registered on P when the operation completes.
module seq_multiplier #(
    parameter int N = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] P,
    output logic           Busy,
    output logic           Done
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_step;
    logic [N:0]     sum;
    logic [CW-1:0]  cnt;

    // Upper half plus (optional) multiplicand keeps its carry; {carry, acc} then shifts right.
    always_comb begin
        sum      = {1'b0, acc[2*N-1:N]} + (mplier[0] ? {1'b0, mcand} : {(N+1){1'b0}});
        acc_step = {sum, acc[N-1:1]};
    end

    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: if (Start) state_nx = RUN;
            RUN: begin
                Busy = 1'b1;
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                Busy     = 1'b1;
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            P      <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (Start) begin
                    mcand  <= A;
                    mplier <= B;
                    acc    <= '0;
                    cnt    <= CW'(N - 1);
                end
                RUN: begin
                    acc    <= acc_step;
                    mplier <= mplier >> 1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    // Last step result goes straight to P so it is visible with Done.
                    else           P   <= acc_step;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at N=8 and N=16: latency, Busy/Done framing,
// Start masking, reset abort, back-to-back throughput and product correctness.
module tb_seq_multiplier;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        s8, s16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic [15:0] p8;
    logic [31:0] p16;
    logic        busy8, done8, busy16, done16;
    int          checks = 0;
    int          errors = 0;

    always #5 Clock = ~Clock;

    seq_multiplier #(.N(8)) dut8 (
        .Clock(Clock), .Reset(Reset), .Start(s8), .A(a8), .B(b8),
        .P(p8), .Busy(busy8), .Done(done8)
    );

    seq_multiplier #(.N(16)) dut16 (
        .Clock(Clock), .Reset(Reset), .Start(s16), .A(a16), .B(b16),
        .P(p16), .Busy(busy16), .Done(done16)
    );

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // Drives one Start pulse and waits (bounded) for Done; lat=-1 on timeout.
    task automatic do_op(input bit w, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int bcnt, output logic [31:0] p,
                         output bit dbl);
        if (w) begin a16 = a; b16 = b; s16 = 1'b1; end
        else   begin a8 = a[7:0]; b8 = b[7:0]; s8 = 1'b1; end
        tick;
        s8 = 1'b0; s16 = 1'b0;
        lat  = -1;
        bcnt = (w ? busy16 : busy8) ? 1 : 0;
        p    = '0;
        dbl  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (w ? busy16 : busy8) bcnt++;
            if (w ? done16 : done8) begin
                lat = i;
                p   = w ? p16 : {16'h0, p8};
                tick;
                dbl = w ? done16 : done8;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; s8 = 1'b1; s16 = 1'b1;
        a8 = 8'd3; b8 = 8'd5; a16 = 16'd3; b16 = 16'd5;
        tick; tick;
        checks++; if (p8 !== 16'h0)   begin errors++; $display("FAIL reset_p8 got %0d exp 0", p8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b exp 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8 got %b exp 0", done8); end
        checks++; if (p16 !== 32'h0)  begin errors++; $display("FAIL reset_p16 got %0d exp 0", p16); end
        s8 = 1'b0; s16 = 1'b0; Reset = 1'b0;
        tick;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_start_discard got busy %b exp 0", busy8); end
    endtask

    task automatic test_basic;
        int lat, bcnt; logic [31:0] p; bit dbl;
        do_op(1'b0, 16'd3, 16'd5, lat, bcnt, p, dbl);
        checks++; if (lat !== 8)      begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
        checks++; if (bcnt !== 9)     begin errors++; $display("FAIL basic_busy_cycles got %0d exp 9", bcnt); end
        checks++; if (p !== 32'd15)   begin errors++; $display("FAIL basic_p got %0d exp 15", p); end
        checks++; if (dbl !== 1'b0)   begin errors++; $display("FAIL basic_done_width got double pulse exp single"); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b exp 0", busy8); end
    endtask

    task automatic test_boundary;
        int lat, bcnt; logic [31:0] p; bit dbl;
        do_op(1'b0, 16'd255, 16'd255, lat, bcnt, p, dbl);
        checks++; if (p !== 32'd65025) begin errors++; $display("FAIL max_p got %0d exp 65025", p); end
        checks++; if (lat !== 8)       begin errors++; $display("FAIL max_latency got %0d exp 8", lat); end
        do_op(1'b0, 16'd0, 16'd200, lat, bcnt, p, dbl);
        checks++; if (p !== 32'd0)     begin errors++; $display("FAIL zero_p got %0d exp 0", p); end
        checks++; if (lat !== 8)       begin errors++; $display("FAIL zero_latency got %0d exp 8", lat); end
        checks++; if (bcnt !== 9)      begin errors++; $display("FAIL zero_busy_cycles got %0d exp 9", bcnt); end
    endtask

    task automatic test_ignore_start;
        int ndone; logic [15:0] pgot;
        ndone = 0; pgot = '0;
        a8 = 8'd7; b8 = 8'd9; s8 = 1'b1;
        tick;
        s8 = 1'b0;
        tick; tick;
        a8 = 8'd1; b8 = 8'd1; s8 = 1'b1;
        tick;
        s8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (done8) begin ndone++; pgot = p8; end
        end
        checks++; if (ndone !== 1)      begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
        checks++; if (pgot !== 16'd63)  begin errors++; $display("FAIL ignore_p got %0d exp 63", pgot); end
        checks++; if (busy8 !== 1'b0)   begin errors++; $display("FAIL ignore_idle_busy got %b exp 0", busy8); end
    endtask

    task automatic test_reset_abort;
        int lat, bcnt, ndone; logic [31:0] p; bit dbl;
        ndone = 0;
        a8 = 8'd10; b8 = 8'd10; s8 = 1'b1;
        tick;
        s8 = 1'b0;
        tick; tick; tick;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done8); end
        checks++; if (p8 !== 16'd0)   begin errors++; $display("FAIL abort_p got %0d exp 0", p8); end
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done8) ndone++;
        end
        checks++; if (ndone !== 0)    begin errors++; $display("FAIL abort_no_done got %0d exp 0", ndone); end
        do_op(1'b0, 16'd10, 16'd10, lat, bcnt, p, dbl);
        checks++; if (p !== 32'd100)  begin errors++; $display("FAIL abort_restart_p got %0d exp 100", p); end
        checks++; if (lat !== 8)      begin errors++; $display("FAIL abort_restart_latency got %0d exp 8", lat); end
    endtask

    task automatic test_back_to_back;
        int t[3]; logic [15:0] pv[3]; int n;
        n = 0;
        for (int k = 0; k < 3; k++) begin t[k] = 0; pv[k] = '0; end
        a8 = 8'd2; b8 = 8'd1; s8 = 1'b1;
        tick;
        for (int c = 1; c <= 60 && n < 3; c++) begin
            tick;
            if (done8) begin
                t[n] = c; pv[n] = p8; n++;
                b8 = b8 + 8'd1;
                if (n == 3) s8 = 1'b0;
            end
        end
        s8 = 1'b0;
        tick; tick;
        checks++; if (n !== 3)            begin errors++; $display("FAIL b2b_count got %0d exp 3", n); end
        checks++; if (t[0] !== 8)         begin errors++; $display("FAIL b2b_first got %0d exp 8", t[0]); end
        checks++; if (t[1] - t[0] !== 10) begin errors++; $display("FAIL b2b_gap1 got %0d exp 10", t[1] - t[0]); end
        checks++; if (t[2] - t[1] !== 10) begin errors++; $display("FAIL b2b_gap2 got %0d exp 10", t[2] - t[1]); end
        checks++; if (pv[0] !== 16'd2)    begin errors++; $display("FAIL b2b_p0 got %0d exp 2", pv[0]); end
        checks++; if (pv[1] !== 16'd4)    begin errors++; $display("FAIL b2b_p1 got %0d exp 4", pv[1]); end
        checks++; if (pv[2] !== 16'd6)    begin errors++; $display("FAIL b2b_p2 got %0d exp 6", pv[2]); end
    endtask

    task automatic test_n16;
        logic [15:0] va[4]; logic [15:0] vb[4]; logic [31:0] ve[4];
        int lat, bcnt; logic [31:0] p; bit dbl;
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; ve[0] = 32'hFFFE0001;
        va[1] = 16'd1234;  vb[1] = 16'd5678; ve[1] = 32'd7006652;
        va[2] = 16'd0;     vb[2] = 16'hFFFF; ve[2] = 32'd0;
        va[3] = 16'd300;   vb[3] = 16'd2;    ve[3] = 32'd600;
        for (int k = 0; k < 4; k++) begin
            do_op(1'b1, va[k], vb[k], lat, bcnt, p, dbl);
            checks++; if (p !== ve[k]) begin errors++; $display("FAIL n16_p[%0d] got %0d exp %0d", k, p, ve[k]); end
            checks++; if (lat !== 16)  begin errors++; $display("FAIL n16_latency[%0d] got %0d exp 16", k, lat); end
            checks++; if (bcnt !== 17) begin errors++; $display("FAIL n16_busy[%0d] got %0d exp 17", k, bcnt); end
        end
    endtask

    task automatic test_random;
        int lat, bcnt; logic [31:0] p, expv; bit dbl; logic [15:0] ra, rb;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 1000; k++) begin
                ra = 16'($urandom); rb = 16'($urandom);
                if (w == 0) begin ra[15:8] = 8'h0; rb[15:8] = 8'h0; end
                expv = 32'(ra) * 32'(rb);
                do_op(w[0], ra, rb, lat, bcnt, p, dbl);
                checks++; if (p !== expv) begin errors++; $display("FAIL rand_p w%0d a=%0d b=%0d got %0d exp %0d", w, ra, rb, p, expv); end
                checks++; if (dbl !== 1'b0) begin errors++; $display("FAIL rand_done_width w%0d a=%0d b=%0d got double pulse exp single", w, ra, rb); end
                checks++; if (lat !== (w == 0 ? 8 : 16)) begin errors++; $display("FAIL rand_latency w%0d got %0d exp %0d", w, lat, (w == 0 ? 8 : 16)); end
            end
        end
    endtask

    initial begin
        Reset = 1'b1; s8 = 1'b0; s16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        test_reset;
        test_basic;
        test_boundary;
        test_ignore_start;
        test_reset_abort;
        test_back_to_back;
        test_n16;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
